// File: rtl/hazard_unit_mdu_if.sv
// Pipeline-to-hazard-unit bundle: stage register/control inputs, stall/flush/forward/MDU outputs.
interface hazard_unit_mdu_if #(
   parameter int RA_W  = 5,
   parameter int CNT_W = 16
);
   logic            RegWriteM, RegWriteW;
   logic [1:0]      ResultSrcE, ResultSrcM, PCSrcE;
   logic            MdStartE;
   logic [RA_W-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW;
   logic            StallF, StallD, StallE;
   logic            FlushD, FlushE, FlushM;
   logic [2:0]      ForwardAE, ForwardBE;
   logic            MdLaunch, MdWb, MdBusy;
   logic [RA_W-1:0] MdRd;
   logic [CNT_W-1:0] StallCnt;

   modport master (
      output RegWriteM, RegWriteW, ResultSrcE, ResultSrcM, PCSrcE, MdStartE,
             Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW,
      input  StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardAE, ForwardBE,
             MdLaunch, MdWb, MdBusy, MdRd, StallCnt
   );

   modport slave (
      input  RegWriteM, RegWriteW, ResultSrcE, ResultSrcM, PCSrcE, MdStartE,
             Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW,
      output StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardAE, ForwardBE,
             MdLaunch, MdWb, MdBusy, MdRd, StallCnt
   );
endinterface

// File: rtl/hazard_unit_mdu.sv
// Hazard unit for the 5-stage pipeline with one out-of-pipe multi-cycle MDU.
// state | meaning
// IDLE  | no MDU op in flight; an E-stage MDU op may launch
// BUSY  | MDU computing, cnt counts down to the writeback slot
// WB    | MDU result ready; waits for a free W write port
module hazard_unit_mdu #(
   parameter int RA_W    = 5,
   parameter int MDU_LAT = 4,
   parameter int CNT_W   = 16
) (
   input logic clk,
   input logic rst_n,
   hazard_unit_mdu_if.slave hz
);
   localparam int CW = $clog2(MDU_LAT + 1);

   typedef enum logic [1:0] {IDLE, BUSY, WB} state_t;

   state_t          state, stateNext;
   logic [CW-1:0]   cnt, cntNext;
   logic            pend, pendNext;
   logic [RA_W-1:0] mdRd, mdRdNext;
   logic [CNT_W-1:0] stallCnt;
   logic            redirect, mdLaunch, mdWb;
   logic            lwStall, sbStall, strStall, wbStall, stallFront;

   function automatic logic [2:0] fwdSel(
      input logic [RA_W-1:0] rs, input logic [RA_W-1:0] rdM, input logic regWriteM,
      input logic [1:0] resultSrcM, input logic wbMdu, input logic [RA_W-1:0] rdMdu,
      input logic [RA_W-1:0] rdW, input logic regWriteW
   );
      logic [2:0] sel;
      sel = 3'b000;
      if (rs != '0) begin
         if (rs == rdM && regWriteM && resultSrcM != 2'b11)      sel = 3'b010;
         else if (rs == rdM && regWriteM)                         sel = 3'b011;
         else if (wbMdu && rs == rdMdu)                           sel = 3'b100;
         else if (rs == rdW && regWriteW)                         sel = 3'b001;
      end
      return sel;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         pend  <= 1'b0;
         mdRd  <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
         pend  <= pendNext;
         mdRd  <= mdRdNext;
      end
   end

   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      pendNext  = pend;
      mdRdNext  = mdRd;
      mdLaunch  = 1'b0;
      mdWb      = 1'b0;
      case (state)
         IDLE: if (hz.MdStartE && !redirect) begin
            mdLaunch  = 1'b1;
            mdRdNext  = hz.RdE;
            pendNext  = (hz.RdE != '0);
            cntNext   = CW'(MDU_LAT - 1);
            stateNext = BUSY;
         end
         BUSY: begin
            cntNext = cnt - CW'(1);
            if (cnt == CW'(1)) stateNext = WB;
         end
         WB: if (!hz.RegWriteW) begin
            // W port free: MDU result takes it; otherwise wbStall empties W for next cycle
            mdWb      = 1'b1;
            pendNext  = 1'b0;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   assign redirect   = (hz.PCSrcE != 2'b00);
   assign lwStall    = (hz.ResultSrcE == 2'b01) && (hz.RdE != '0) &&
                       ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));
   assign sbStall    = pend && (mdRd != '0) &&
                       ((hz.Rs1D == mdRd) || (hz.Rs2D == mdRd) || (hz.RdD == mdRd));
   assign strStall   = hz.MdStartE && (state != IDLE);
   assign wbStall    = (state == WB) && hz.RegWriteW;
   assign stallFront = (lwStall || sbStall || strStall || wbStall) && !redirect;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          stallCnt <= '0;
      else if (stallFront && stallCnt != '1) stallCnt <= stallCnt + CNT_W'(1);
   end

   assign hz.StallF    = stallFront;
   assign hz.StallD    = stallFront;
   assign hz.StallE    = strStall || wbStall;
   assign hz.FlushD    = redirect;
   assign hz.FlushE    = lwStall || sbStall || redirect;
   assign hz.FlushM    = strStall || wbStall;
   assign hz.ForwardAE = fwdSel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.ResultSrcM, mdWb, mdRd,
                                hz.RdW, hz.RegWriteW);
   assign hz.ForwardBE = fwdSel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.ResultSrcM, mdWb, mdRd,
                                hz.RdW, hz.RegWriteW);
   assign hz.MdLaunch  = mdLaunch;
   assign hz.MdWb      = mdWb;
   assign hz.MdRd      = mdRd;
   assign hz.MdBusy    = (state != IDLE);
   assign hz.StallCnt  = stallCnt;
endmodule

// File: tb/tb_hazard_unit_mdu.sv
// Scenario bench for hazard_unit_mdu (MDU_LAT=4, CNT_W=4 so counter saturation is reachable).
module tb_hazard_unit_mdu;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   logic [19:0] expQ[$];
   int          cntQ[$];

   always #5 clk = ~clk;

   hazard_unit_mdu_if #(.RA_W(5), .CNT_W(4)) hzBus ();
   hazard_unit_mdu #(.RA_W(5), .MDU_LAT(4), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .hz(hzBus));

   // {StallF,StallD,StallE,FlushD,FlushE,FlushM}, ForwardAE, ForwardBE, MdLaunch, MdWb, MdBusy, MdRd
   function automatic logic [19:0] mk(input logic [5:0] sf, input logic [2:0] fa, input logic [2:0] fb,
                                      input logic la, input logic wb, input logic busy, input logic [4:0] rd);
      return {sf, fa, fb, la, wb, busy, rd};
   endfunction

   function automatic logic [19:0] curOut();
      return {hzBus.StallF, hzBus.StallD, hzBus.StallE, hzBus.FlushD, hzBus.FlushE, hzBus.FlushM,
              hzBus.ForwardAE, hzBus.ForwardBE, hzBus.MdLaunch, hzBus.MdWb, hzBus.MdBusy, hzBus.MdRd};
   endfunction

   task automatic clearIn();
      hzBus.RegWriteM = 0; hzBus.RegWriteW = 0; hzBus.ResultSrcE = 0; hzBus.ResultSrcM = 0;
      hzBus.PCSrcE = 0; hzBus.MdStartE = 0;
      hzBus.Rs1D = 0; hzBus.Rs2D = 0; hzBus.RdD = 0; hzBus.Rs1E = 0; hzBus.Rs2E = 0;
      hzBus.RdE = 0; hzBus.RdM = 0; hzBus.RdW = 0;
   endtask

   task automatic applyReset();
      rst_n = 1'b0;
      clearIn();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [19:0] a, e;
      rst_n = 1'b0;
      clearIn();
      for (int i = 0; i < 3; i++) begin
         expQ.push_back(mk(6'b0, 3'b0, 3'b0, 0, 0, 0, 5'd0));
         cntQ.push_back(0);
         @(negedge clk);
         a = curOut(); e = expQ.pop_front();
         checks++;
         if (a !== e) begin failures++; $display("FAIL reset_out[%0d] actual=%h required=%h", i, a, e); end
         checks++;
         if (int'(hzBus.StallCnt) != cntQ.pop_front()) begin
            failures++; $display("FAIL reset_cnt[%0d] actual=%0d required=0", i, hzBus.StallCnt);
         end
         @(posedge clk); #1;
         if (i == 0) rst_n = 1'b1;
      end
   endtask

   task automatic test_load_use();
      logic [19:0] a, e;
      applyReset();
      for (int i = 0; i < 4; i++) begin
         clearIn();
         case (i)
            0: begin hzBus.ResultSrcE = 2'b01; hzBus.RdE = 5; hzBus.Rs1D = 5; expQ.push_back(mk(6'b110010, 0, 0, 0, 0, 0, 0)); end
            1: begin hzBus.ResultSrcE = 2'b01; hzBus.RdE = 0; hzBus.Rs1D = 0; expQ.push_back(mk(6'b000000, 0, 0, 0, 0, 0, 0)); end
            2: begin hzBus.ResultSrcE = 2'b01; hzBus.RdE = 5; hzBus.Rs2D = 5; expQ.push_back(mk(6'b110010, 0, 0, 0, 0, 0, 0)); end
            default: begin hzBus.ResultSrcE = 2'b00; hzBus.RdE = 5; hzBus.Rs1D = 5; expQ.push_back(mk(6'b000000, 0, 0, 0, 0, 0, 0)); end
         endcase
         @(negedge clk);
         a = curOut(); e = expQ.pop_front();
         checks++;
         if (a !== e) begin failures++; $display("FAIL load_use[%0d] actual=%h required=%h", i, a, e); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mdu_latency();
      logic [19:0] a, e;
      applyReset();
      for (int i = 0; i < 6; i++) begin
         clearIn();
         case (i)
            0: begin hzBus.MdStartE = 1; hzBus.RdE = 7; expQ.push_back(mk(6'b0, 0, 0, 1, 0, 0, 0)); end
            4: begin hzBus.Rs1E = 7; expQ.push_back(mk(6'b0, 3'b100, 0, 0, 1, 1, 7)); end
            5: expQ.push_back(mk(6'b0, 0, 0, 0, 0, 0, 7));
            default: expQ.push_back(mk(6'b0, 0, 0, 0, 0, 1, 7));
         endcase
         @(negedge clk);
         a = curOut(); e = expQ.pop_front();
         checks++;
         if (a !== e) begin failures++; $display("FAIL mdu_latency[%0d] actual=%h required=%h", i, a, e); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_scoreboard();
      logic [19:0] a, e;
      applyReset();
      for (int i = 0; i < 8; i++) begin
         clearIn();
         case (i)
            0: begin hzBus.MdStartE = 1; hzBus.RdE = 7; expQ.push_back(mk(6'b0, 0, 0, 1, 0, 0, 0)); end
            1: begin hzBus.Rs2D = 7; expQ.push_back(mk(6'b110010, 0, 0, 0, 0, 1, 7)); end
            2: begin hzBus.RdD = 7;  expQ.push_back(mk(6'b110010, 0, 0, 0, 0, 1, 7)); end
            3: begin hzBus.Rs2D = 8; expQ.push_back(mk(6'b000000, 0, 0, 0, 0, 1, 7)); end
            4: begin hzBus.Rs1D = 7; expQ.push_back(mk(6'b110010, 0, 0, 0, 1, 1, 7)); end
            5: begin hzBus.Rs1D = 7; expQ.push_back(mk(6'b000000, 0, 0, 0, 0, 0, 7)); end
            6: begin hzBus.MdStartE = 1; hzBus.RdE = 0; expQ.push_back(mk(6'b0, 0, 0, 1, 0, 0, 7)); end
            default: expQ.push_back(mk(6'b000000, 0, 0, 0, 0, 1, 0));
         endcase
         @(negedge clk);
         a = curOut(); e = expQ.pop_front();
         checks++;
         if (a !== e) begin failures++; $display("FAIL scoreboard[%0d] actual=%h required=%h", i, a, e); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_structural();
      logic [19:0] a, e;
      applyReset();
      for (int i = 0; i < 7; i++) begin
         clearIn();
         case (i)
            0: begin hzBus.MdStartE = 1; hzBus.RdE = 9; expQ.push_back(mk(6'b0, 0, 0, 1, 0, 0, 0)); end
            4: begin hzBus.MdStartE = 1; hzBus.RdE = 10; expQ.push_back(mk(6'b111001, 0, 0, 0, 1, 1, 9)); end
            5: begin hzBus.MdStartE = 1; hzBus.RdE = 10; expQ.push_back(mk(6'b000000, 0, 0, 1, 0, 0, 9)); end
            6: expQ.push_back(mk(6'b000000, 0, 0, 0, 0, 1, 10));
            default: begin hzBus.MdStartE = 1; hzBus.RdE = 10; expQ.push_back(mk(6'b111001, 0, 0, 0, 0, 1, 9)); end
         endcase
         @(negedge clk);
         a = curOut(); e = expQ.pop_front();
         checks++;
         if (a !== e) begin failures++; $display("FAIL structural[%0d] actual=%h required=%h", i, a, e); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_wb_port();
      logic [19:0] a, e;
      applyReset();
      for (int i = 0; i < 7; i++) begin
         clearIn();
         case (i)
            0: begin hzBus.MdStartE = 1; hzBus.RdE = 4; expQ.push_back(mk(6'b0, 0, 0, 1, 0, 0, 0)); end
            4: begin hzBus.RegWriteW = 1; hzBus.RdW = 4; hzBus.Rs1E = 4;
                     expQ.push_back(mk(6'b111001, 3'b001, 0, 0, 0, 1, 4)); end
            5: begin hzBus.Rs1E = 4; expQ.push_back(mk(6'b000000, 3'b100, 0, 0, 1, 1, 4)); end
            6: expQ.push_back(mk(6'b000000, 0, 0, 0, 0, 0, 4));
            default: expQ.push_back(mk(6'b000000, 0, 0, 0, 0, 1, 4));
         endcase
         @(negedge clk);
         a = curOut(); e = expQ.pop_front();
         checks++;
         if (a !== e) begin failures++; $display("FAIL wb_port[%0d] actual=%h required=%h", i, a, e); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_redirect();
      logic [19:0] a, e;
      applyReset();
      for (int i = 0; i < 7; i++) begin
         clearIn();
         case (i)
            0: begin hzBus.MdStartE = 1; hzBus.RdE = 7; expQ.push_back(mk(6'b0, 0, 0, 1, 0, 0, 0)); end
            1: begin hzBus.Rs1D = 7; hzBus.PCSrcE = 2'b01; expQ.push_back(mk(6'b000110, 0, 0, 0, 0, 1, 7)); end
            2: begin hzBus.MdStartE = 1; hzBus.RdE = 12; hzBus.PCSrcE = 2'b10;
                     expQ.push_back(mk(6'b001111, 0, 0, 0, 0, 1, 7)); end
            3: expQ.push_back(mk(6'b000000, 0, 0, 0, 0, 1, 7));
            4: expQ.push_back(mk(6'b000000, 0, 0, 0, 1, 1, 7));
            5: begin hzBus.MdStartE = 1; hzBus.RdE = 12; hzBus.PCSrcE = 2'b10;
                     expQ.push_back(mk(6'b000110, 0, 0, 0, 0, 0, 7)); end
            default: expQ.push_back(mk(6'b000000, 0, 0, 0, 0, 0, 7));
         endcase
         @(negedge clk);
         a = curOut(); e = expQ.pop_front();
         checks++;
         if (a !== e) begin failures++; $display("FAIL redirect[%0d] actual=%h required=%h", i, a, e); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_forward();
      logic [19:0] a, e;
      applyReset();
      for (int i = 0; i < 5; i++) begin
         clearIn();
         hzBus.RdM = 3; hzBus.RdW = 3; hzBus.Rs1E = 3; hzBus.Rs2E = 3;
         hzBus.RegWriteM = 1; hzBus.RegWriteW = 1;
         case (i)
            0: expQ.push_back(mk(6'b0, 3'b010, 3'b010, 0, 0, 0, 0));
            1: begin hzBus.ResultSrcM = 2'b11; expQ.push_back(mk(6'b0, 3'b011, 3'b011, 0, 0, 0, 0)); end
            2: begin hzBus.RegWriteM = 0; expQ.push_back(mk(6'b0, 3'b001, 3'b001, 0, 0, 0, 0)); end
            3: begin hzBus.RegWriteM = 0; hzBus.Rs1E = 0; hzBus.RdW = 0; hzBus.RdM = 0;
                     expQ.push_back(mk(6'b0, 3'b000, 3'b000, 0, 0, 0, 0)); end
            default: begin hzBus.RegWriteM = 0; hzBus.RegWriteW = 0;
                     expQ.push_back(mk(6'b0, 3'b000, 3'b000, 0, 0, 0, 0)); end
         endcase
         @(negedge clk);
         a = curOut(); e = expQ.pop_front();
         checks++;
         if (a !== e) begin failures++; $display("FAIL forward[%0d] actual=%h required=%h", i, a, e); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_counter();
      int modelCnt = 0;
      int got;
      applyReset();
      for (int i = 0; i < 25; i++) begin
         clearIn();
         if (i != 3 && i != 4) begin hzBus.ResultSrcE = 2'b01; hzBus.RdE = 6; hzBus.Rs1D = 6; end
         cntQ.push_back(modelCnt);
         @(negedge clk);
         got = int'(hzBus.StallCnt);
         checks++;
         if (got != cntQ.pop_front()) begin
            failures++; $display("FAIL stall_cnt[%0d] actual=%0d required=%0d", i, got, modelCnt);
         end
         if (i != 3 && i != 4 && modelCnt < 15) modelCnt++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid();
      logic [19:0] a, e;
      applyReset();
      for (int i = 0; i < 8; i++) begin
         clearIn();
         case (i)
            0: begin hzBus.MdStartE = 1; hzBus.RdE = 7; expQ.push_back(mk(6'b0, 0, 0, 1, 0, 0, 0)); end
            1: begin hzBus.RdD = 7; expQ.push_back(mk(6'b110010, 0, 0, 0, 0, 1, 7)); end
            2: begin rst_n = 1'b0; expQ.push_back(mk(6'b0, 0, 0, 0, 0, 0, 0)); end
            default: begin rst_n = 1'b1; expQ.push_back(mk(6'b0, 0, 0, 0, 0, 0, 0)); end
         endcase
         @(negedge clk);
         a = curOut(); e = expQ.pop_front();
         checks++;
         if (a !== e) begin failures++; $display("FAIL reset_mid[%0d] actual=%h required=%h", i, a, e); end
         if (i == 2) begin
            checks++;
            if (hzBus.StallCnt !== 4'd0) begin
               failures++; $display("FAIL reset_mid_cnt actual=%0d required=0", hzBus.StallCnt);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      clearIn();
      test_reset();
      test_load_use();
      test_mdu_latency();
      test_scoreboard();
      test_structural();
      test_wb_port();
      test_redirect();
      test_forward();
      test_counter();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hazard_unit_mdu.md
Name: hazard_unit_mdu

Overview:
- Next-generation hazard unit for the 5-stage RISC-V pipeline (F/D/E/M/W).
- Adds support for one out-of-pipe multi-cycle multiply/divide unit (MDU) that is launched from E and writes back through the W register-file port.
- Keeps the existing forwarding and load-use stall behaviour, and adds:
  - a single-entry scoreboard with a RAW/WAW stall for the pending MDU destination;
  - a structural stall for a second MDU op while one is in flight;
  - writeback-port arbitration;
  - a saturating stall-cycle counter.

Parameters:
RA_W, 5, register address width
MDU_LAT, 4, cycles from launch to MDU result valid (>=2)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset
RegWriteM  in  1  M-stage instruction writes RF
RegWriteW  in  1  W-stage instruction writes RF
ResultSrcE  in  2  E result select (01 = load)
ResultSrcM  in  2  M result select (11 = immediate/lui)
PCSrcE  in  2  redirect from E (any nonzero value = taken/jump)
MdStartE  in  1  E holds a valid MDU instruction
Rs1D, Rs2D, RdD  in  RA_W  D-stage source/destination registers
Rs1E, Rs2E, RdE  in  RA_W  E-stage source/destination registers
RdM, RdW  in  RA_W  M and W destination registers
StallF, StallD, StallE  out  1  hold stage register
FlushD, FlushE, FlushM  out  1  bubble stage register
ForwardAE, ForwardBE  out  3  operand source select
MdLaunch  out  1  start the MDU this cycle
MdWb  out  1  MDU owns the W write port this cycle
MdRd  out  RA_W  destination register of the in-flight MDU op
MdBusy  out  1  state != IDLE
StallCnt  out  CNT_W  saturating count of cycles with StallF=1

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, cnt=0, pend=0, MdRd=0, StallCnt=0. With all inputs 0 after reset, every output is 0.
- Forwarding codes (each operand independently; Rs==0 always gives 000). Priority, highest first:
  - 010: Rs==RdM and RegWriteM and ResultSrcM!=11 (M ALU result).
  - 011: Rs==RdM and RegWriteM and ResultSrcM==11 (M immediate).
  - 100: MdWb and Rs==MdRd (MDU result).
  - 001: Rs==RdW and RegWriteW (W result).
  - 000: register file.
- lwStall: ResultSrcE==01, RdE!=0, and (Rs1D==RdE or Rs2D==RdE).
- sbStall: pend, MdRd!=0, and any of Rs1D, Rs2D, RdD equals MdRd (RAW and WAW). It stays asserted during the grant cycle and releases the cycle after.
- strStall: MdStartE and state!=IDLE.
- wbStall: state==WB and RegWriteW.
- MDU FSM:
  - IDLE: if MdStartE and no redirect, then MdLaunch=1, MdRd<=RdE, pend<=(RdE!=0), cnt<=MDU_LAT-1, go to BUSY.
  - BUSY: cnt decrements each cycle; when cnt==1, go to WB.
  - WB: if !RegWriteW, then MdWb=1, pend<=0, go to IDLE. Otherwise stay in WB; wbStall holds F/D/E and flushes M, so W is empty the next cycle and the grant is guaranteed by cycle +1.
  - Launch-to-MdWb latency is exactly MDU_LAT cycles when there is no conflict.
  - No launch is possible in the WB grant cycle; a new launch earliest happens the following cycle.
- Stall outputs:
  - StallF = StallD = lwStall | sbStall | strStall | wbStall, gated off when PCSrcE!=0.
  - StallE = strStall | wbStall.
  - FlushE = (lwStall | sbStall) | (PCSrcE!=0).
  - FlushD = PCSrcE!=0.
  - FlushM = strStall | wbStall.
- Redirect wins over D-side stalls: a branch in E with a simultaneous sbStall gives StallF=StallD=0 and FlushD=FlushE=1. A flushed MDU op in E never launches.
- StallCnt: increments on every cycle with StallF=1 and saturates at all-ones; no wrap.
- Reset asserted mid-operation: FSM returns to IDLE, pend clears, no MdWb is issued.

Test Plan:
- Load-use: ResultSrcE=01, RdE=5, Rs1D=5 -> StallF=StallD=FlushE=1 for one cycle, ForwardAE=000. Repeat with RdE=0 -> no stall.
- MDU latency: MdStartE=1, RdE=7, MDU_LAT=4, RegWriteW=0 -> MdLaunch at cycle t, MdBusy cycles t+1..t+4, MdWb=1 at t+4. With Rs1E=7 at t+4 -> ForwardAE=100. MdRd=7 throughout.
- Scoreboard: MDU in flight to x7; D reads Rs2D=7, then RdD=7 -> stall each cycle until the grant cycle inclusive, released the next cycle. Rs2D=8 -> no stall. MdRd=0 -> no stall.
- Structural and port conflict:
  - Second MdStartE while BUSY -> StallF/D/E=1, FlushM=1 until IDLE.
  - RegWriteW=1 in the WB cycle -> MdWb=0 with wbStall; next cycle MdWb=1.
- Redirect priority: PCSrcE=01 during sbStall -> StallF=StallD=0, FlushD=FlushE=1. PCSrcE=10 with MdStartE -> no MdLaunch.
- Forward priority and counter: RdM=RdW=3, RegWriteM=RegWriteW=1, Rs1E=3 -> 010; ResultSrcM=11 -> 011. StallCnt with CNT_W=4 after 20 stall cycles -> 15. rst_n low mid-BUSY -> all outputs 0.
